// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_unit
// Description : Next-PC selection with fetch handshake, redirect pulse and
//               sticky misaligned-target trap.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        jump,
    input  logic        jalr,
    input  logic        branch_taken,
    input  logic [31:0] imm_ext,
    input  logic [31:0] rs1_val,
    input  logic        fetch_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        redirect,
    output logic        misalign
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] w_target;
    logic [31:0] w_jalr_sum;
    logic        r_redirect;
    logic        w_redirect_next;
    logic        r_misalign;
    logic        w_misalign_next;
    logic        w_update;
    logic        w_taken;

    assign pc          = r_pc;
    assign pc_plus4    = r_pc + 32'd4;
    assign redirect    = r_redirect;
    assign misalign    = r_misalign;
    // Gated by rst so no fetch request is presented while reset is held.
    assign fetch_valid = (r_state != TRAP) && !rst;
    assign w_update    = fetch_valid && fetch_ready && !stall;
    assign w_jalr_sum  = rs1_val + imm_ext;
    assign w_taken     = jalr || jump || branch_taken;

    always_comb begin
        w_target = r_pc + 32'd4;
        if (jalr) begin
            w_target = {w_jalr_sum[31:1], 1'b0};
        end else if (jump || branch_taken) begin
            w_target = r_pc + imm_ext;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_redirect_next = 1'b0;
        w_misalign_next = r_misalign;
        case (r_state)
            RUN, HOLD: begin
                if (w_update) begin
                    // Only bit 1 is checked: bit 0 is masked (JALR) or even by construction.
                    if (w_target[1]) begin
                        w_state_next    = TRAP;
                        w_misalign_next = 1'b1;
                    end else begin
                        w_state_next    = RUN;
                        w_pc_next       = w_target;
                        w_redirect_next = w_taken;
                    end
                end else begin
                    w_state_next = HOLD;
                end
            end
            TRAP: begin
                w_state_next    = TRAP;
                w_misalign_next = 1'b1;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_redirect <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_redirect <= w_redirect_next;
            r_misalign <= w_misalign_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_next_unit
// Description : Directed self-checking bench for pc_next_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_next_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jump;
    logic        jalr;
    logic        branch_taken;
    logic [31:0] imm_ext;
    logic [31:0] rs1_val;
    logic        fetch_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        redirect;
    logic        misalign;
    logic [31:0] pc_w;
    logic [31:0] pc_plus4_w;
    logic        fetch_valid_w;
    logic        redirect_w;
    logic        misalign_w;

    int checks   = 0;
    int failures = 0;

    pc_next_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jalr(jalr),
        .branch_taken(branch_taken), .imm_ext(imm_ext), .rs1_val(rs1_val),
        .fetch_ready(fetch_ready), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .redirect(redirect), .misalign(misalign)
    );

    // Second instance exercises the wrap-around reset address.
    pc_next_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall), .jump(jump), .jalr(jalr),
        .branch_taken(branch_taken), .imm_ext(imm_ext), .rs1_val(rs1_val),
        .fetch_ready(fetch_ready), .pc(pc_w), .pc_plus4(pc_plus4_w),
        .fetch_valid(fetch_valid_w), .redirect(redirect_w), .misalign(misalign_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        jump         = 1'b0;
        jalr         = 1'b0;
        branch_taken = 1'b0;
        imm_ext      = 32'h0;
        rs1_val      = 32'h0;
        fetch_ready  = 1'b0;
        step();
        step();

        // Reset state
        check("rst_pc", pc, 32'h0);
        check("rst_fv", {31'b0, fetch_valid}, 32'h0);
        check("rst_redir", {31'b0, redirect}, 32'h0);
        check("rst_mis", {31'b0, misalign}, 32'h0);
        check("rst_pc_wrap", pc_w, 32'hFFFF_FFFC);
        check("rst_pc4_wrap", pc_plus4_w, 32'h0);

        rst         = 1'b0;
        fetch_ready = 1'b1;
        #1;
        check("fv_after_rst", {31'b0, fetch_valid}, 32'h1);

        // Sequential fetch
        step();
        check("seq_pc1", pc, 32'h4);
        check("seq_redir1", {31'b0, redirect}, 32'h0);
        check("wrap_pc", pc_w, 32'h0);
        check("wrap_mis", {31'b0, misalign_w}, 32'h0);
        step();
        check("seq_pc2", pc, 32'h8);
        check("seq_redir2", {31'b0, redirect}, 32'h0);
        step();
        check("seq_pc3", pc, 32'hC);
        check("seq_redir3", {31'b0, redirect}, 32'h0);

        // Branch forward to 0x100
        branch_taken = 1'b1;
        imm_ext      = 32'h0000_00F4;
        step();
        check("br_pc", pc, 32'h100);
        check("br_redir", {31'b0, redirect}, 32'h1);

        // JAL with negative offset, back-to-back with the branch
        branch_taken = 1'b0;
        jump         = 1'b1;
        imm_ext      = 32'hFFFF_FFF0;
        #1;
        check("jal_pc4", pc_plus4, 32'h104);
        step();
        check("jal_pc", pc, 32'hF0);
        check("jal_redir", {31'b0, redirect}, 32'h1);
        jump = 1'b0;
        step();
        check("post_jal_pc", pc, 32'hF4);
        check("post_jal_redir", {31'b0, redirect}, 32'h0);

        // Backpressure with jump held
        fetch_ready = 1'b0;
        jump        = 1'b1;
        imm_ext     = 32'h0000_0010;
        step();
        check("bp_pc1", pc, 32'hF4);
        check("bp_redir1", {31'b0, redirect}, 32'h0);
        check("bp_fv", {31'b0, fetch_valid}, 32'h1);
        step();
        check("bp_pc2", pc, 32'hF4);
        fetch_ready = 1'b1;
        step();
        check("bp_take_pc", pc, 32'h104);
        check("bp_take_redir", {31'b0, redirect}, 32'h1);
        jump = 1'b0;
        step();
        check("bp_once_pc", pc, 32'h108);
        check("bp_once_redir", {31'b0, redirect}, 32'h0);

        // Branch while stalled is ignored
        stall        = 1'b1;
        branch_taken = 1'b1;
        imm_ext      = 32'h0000_0020;
        step();
        check("stall_pc", pc, 32'h108);
        check("stall_redir", {31'b0, redirect}, 32'h0);
        stall        = 1'b0;
        branch_taken = 1'b0;
        step();
        check("unstall_pc", pc, 32'h10C);

        // Priority: jalr beats jump and branch, bit 0 cleared
        jalr         = 1'b1;
        jump         = 1'b1;
        branch_taken = 1'b1;
        rs1_val      = 32'h0000_2001;
        imm_ext      = 32'h0000_0003;
        step();
        check("jalr_pc", pc, 32'h2004);
        check("jalr_redir", {31'b0, redirect}, 32'h1);

        // Misaligned JALR target traps
        jump         = 1'b0;
        branch_taken = 1'b0;
        rs1_val      = 32'h0000_2002;
        imm_ext      = 32'h0;
        step();
        check("trap_pc", pc, 32'h2004);
        check("trap_mis", {31'b0, misalign}, 32'h1);
        check("trap_fv", {31'b0, fetch_valid}, 32'h0);
        check("trap_redir", {31'b0, redirect}, 32'h0);

        // Trap is absorbing
        jalr    = 1'b0;
        jump    = 1'b1;
        imm_ext = 32'h0000_0008;
        step();
        check("trap_hold_pc", pc, 32'h2004);
        check("trap_hold_redir", {31'b0, redirect}, 32'h0);
        check("trap_hold_mis", {31'b0, misalign}, 32'h1);
        jump = 1'b0;

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        check("async_pc", pc, 32'h0);
        check("async_mis", {31'b0, misalign}, 32'h0);
        check("async_fv", {31'b0, fetch_valid}, 32'h0);
        #1;
        rst = 1'b0;
        #1;
        check("async_fv_rel", {31'b0, fetch_valid}, 32'h1);
        step();
        check("async_seq_pc", pc, 32'h4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pc_next_unit.md
PC_NEXT_UNIT -- requirements
Module: pc_next_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 The block SHALL provide the following ports, in this order:
- clk  input  1  system clock; rising edge active.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  holds the PC when high.
- jump  input  1  JAL taken this cycle.
- jalr  input  1  JALR taken this cycle.
- branch_taken  input  1  conditional branch resolved taken.
- imm_ext  input  32  extended immediate offset from the immediate-extension stage.
- rs1_val  input  32  rs1 operand, used for JALR.
- fetch_ready  input  1  instruction memory accepts the current address.
- pc  output  32  current fetch address.
- pc_plus4  output  32  combinational pc + 4, used as the link value.
- fetch_valid  output  1  pc is a valid fetch request.
- redirect  output  1  one-cycle pulse after a taken control transfer.
- misalign  output  1  sticky misaligned-target trap flag.

Function
REQ-003 The block SHALL implement a three-state FSM with states RUN, HOLD and TRAP.
REQ-004 fetch_valid SHALL be 1 in RUN and HOLD, and 0 in TRAP.
REQ-005 An update event SHALL be defined as a rising edge where fetch_valid=1, fetch_ready=1 and stall=0.
REQ-006 pc SHALL change only on an update event; otherwise it holds its value.
REQ-007 Control inputs (jump, jalr, branch_taken, imm_ext, rs1_val) SHALL be sampled only at an update event and ignored otherwise.
REQ-008 Target selection priority SHALL be jalr > jump > branch_taken > sequential.
REQ-009 The JALR target SHALL be (rs1_val + imm_ext) with bit 0 forced to 0, computed modulo 2^32.
REQ-010 The jump and branch target SHALL be pc + imm_ext, modulo 2^32, with imm_ext treated as a two's-complement offset.
REQ-011 The sequential target SHALL be pc + 4, modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-012 pc_plus4 SHALL be combinational pc + 4 with the same wrap rule, independent of state.
REQ-013 RUN transitions:
- fetch_ready=0 or stall=1 -> HOLD, pc unchanged.
- Update with a target whose bit 1 = 1 (after the JALR bit-0 mask) -> TRAP, pc unchanged, misalign set.
- Any other update -> stay in RUN with pc loaded.
REQ-014 HOLD SHALL return to RUN on the first update event and perform that update exactly as RUN would, including the misalignment check.
REQ-015 TRAP SHALL be absorbing until rst: pc frozen, fetch_valid=0, redirect=0, misalign=1, all inputs ignored.
REQ-016 redirect SHALL be registered and equal 1 for exactly the cycle after an update whose selected target is non-sequential; it is 0 otherwise, including back-to-back sequential updates.
REQ-017 Back-to-back taken updates SHALL each produce their own redirect pulse, so redirect stays high for consecutive cycles.
REQ-018 jump, jalr or branch_taken asserted while stall=1 SHALL have no effect on pc or redirect.
REQ-019 The misalignment check SHALL consider bit 1 only; bit 0 of the jump/branch targets is never set because imm_ext is even by construction and is not checked.

Reset
REQ-020 When rst=1, the block SHALL asynchronously force pc=RESET_PC, state=RUN, redirect=0 and misalign=0.
REQ-021 During reset, fetch_valid SHALL be 0 and SHALL assert in the first cycle after rst deasserts.
REQ-022 rst asserted mid-HOLD or in TRAP SHALL abort the in-flight state immediately with no pending update retained.

Verification
REQ-023 Sequential fetch: reset, fetch_ready=1 for 3 cycles -> pc = 0, 4, 8, 12; redirect=0 throughout.
REQ-024 JAL: pc=0x100, jump=1, imm_ext=0xFFFF_FFF0 -> next pc=0xF0, redirect=1 for one cycle, pc_plus4=0x104 before the edge.
REQ-025 Priority and JALR: jalr=1, jump=1, rs1_val=0x2001, imm_ext=0x3 -> pc=0x2004; then rs1_val=0x2002, imm_ext=0 -> TRAP, misalign=1, fetch_valid=0, pc holds 0x2004.
REQ-026 Backpressure: fetch_ready=0 for 2 cycles with jump=1 held -> pc unchanged; on fetch_ready=1 the jump is taken exactly once.
REQ-027 Wrap: RESET_PC=0xFFFF_FFFC, one update -> pc=0x0000_0000, misalign=0.
REQ-028 Async reset in TRAP: assert rst between clock edges -> pc=RESET_PC and misalign=0 immediately, without waiting for a clock edge.
